// File: rtl/pipeline_run_controller.sv
// ============================================================================
// Module   : pipeline_run_controller
// Brief    : Run/step/dump controller for a pipelined core with register-file
//            dump port. Define PIPELINE_CYCLE_COUNTER_EN to build the enabled
//            cycle counter; otherwise o_cycle_count is tied to zero.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipeline_run_controller #(
   parameter int STEP_CYCLES = 1
) (
   input  logic        clk,
   input  logic        i_rst_n,
   input  logic        i_cmd_valid,
   input  logic [1:0]  i_cmd,
   output logic        o_cmd_ready,
   input  logic        i_halt,
   output logic        o_pipe_enable,
   output logic        o_pipe_flush,
   output logic        o_dbg_sel,
   output logic [4:0]  o_dbg_addr,
   output logic        o_dump_valid,
   input  logic        i_dump_ready,
   output logic [2:0]  o_state,
   output logic [31:0] o_cycle_count
);

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_RUN  = 3'd1,
      ST_STEP = 3'd2,
      ST_DUMP = 3'd3,
      ST_DONE = 3'd4
   } state_t;

   localparam logic [1:0] CMD_RUN  = 2'b00;
   localparam logic [1:0] CMD_STEP = 2'b01;
   localparam logic [1:0] CMD_DUMP = 2'b10;
   localparam logic [1:0] CMD_STOP = 2'b11;
   localparam logic [7:0] STEP_LOAD = 8'(STEP_CYCLES);

   state_t     state_q, state_d;
   logic [7:0] step_cnt_q, step_cnt_d;
   logic [4:0] dbg_addr_q, dbg_addr_d;
   logic       ret_done_q, ret_done_d;
   logic       flush_q, flush_d;

   logic       cmd_ready;
   logic       cmd_fire;
   logic       pipe_enable;
   logic       in_dump;

   assign cmd_ready   = (state_q == ST_IDLE) || (state_q == ST_RUN) || (state_q == ST_DONE);
   assign cmd_fire    = i_cmd_valid && cmd_ready;
   assign pipe_enable = (state_q == ST_RUN) || (state_q == ST_STEP);
   assign in_dump     = (state_q == ST_DUMP);

   always_comb begin
      state_d    = state_q;
      step_cnt_d = step_cnt_q;
      dbg_addr_d = dbg_addr_q;
      ret_done_d = ret_done_q;
      flush_d    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (cmd_fire) begin
               if (i_cmd == CMD_RUN) begin
                  state_d = ST_RUN;
               end else if (i_cmd == CMD_STEP) begin
                  state_d    = ST_STEP;
                  step_cnt_d = STEP_LOAD;
               end else if (i_cmd == CMD_DUMP) begin
                  state_d    = ST_DUMP;
                  ret_done_d = 1'b0;
                  dbg_addr_d = 5'd0;
               end
            end
         end
         ST_RUN: begin
            // Halt wins over a simultaneous STOP so the halted state is kept.
            if (i_halt) begin
               state_d = ST_DONE;
            end else if (cmd_fire && (i_cmd == CMD_STOP)) begin
               state_d = ST_IDLE;
            end
         end
         ST_STEP: begin
            step_cnt_d = step_cnt_q - 8'd1;
            if (i_halt) begin
               state_d    = ST_DONE;
               step_cnt_d = 8'd0;
            end else if (step_cnt_q <= 8'd1) begin
               state_d    = ST_IDLE;
               step_cnt_d = 8'd0;
            end
         end
         ST_DUMP: begin
            if (i_dump_ready) begin
               if (dbg_addr_q == 5'd31) begin
                  dbg_addr_d = 5'd0;
                  state_d    = ret_done_q ? ST_DONE : ST_IDLE;
               end else begin
                  dbg_addr_d = dbg_addr_q + 5'd1;
               end
            end
         end
         ST_DONE: begin
            if (cmd_fire) begin
               if (i_cmd == CMD_DUMP) begin
                  state_d    = ST_DUMP;
                  ret_done_d = 1'b1;
                  dbg_addr_d = 5'd0;
               end else if (i_cmd == CMD_STOP) begin
                  state_d = ST_IDLE;
                  flush_d = 1'b1;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q    <= ST_IDLE;
         step_cnt_q <= 8'd0;
         dbg_addr_q <= 5'd0;
         ret_done_q <= 1'b0;
         flush_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         step_cnt_q <= step_cnt_d;
         dbg_addr_q <= dbg_addr_d;
         ret_done_q <= ret_done_d;
         flush_q    <= flush_d;
      end
   end

`ifdef PIPELINE_CYCLE_COUNTER_EN
   logic [31:0] cycle_cnt_q, cycle_cnt_d;

   always_comb begin
      cycle_cnt_d = cycle_cnt_q;
      if (flush_q) begin
         cycle_cnt_d = 32'd0;
      end else if (pipe_enable) begin
         cycle_cnt_d = cycle_cnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         cycle_cnt_q <= 32'd0;
      end else begin
         cycle_cnt_q <= cycle_cnt_d;
      end
   end

   assign o_cycle_count = cycle_cnt_q;
`else
   assign o_cycle_count = 32'd0;
`endif

   assign o_cmd_ready   = cmd_ready;
   assign o_pipe_enable = pipe_enable;
   assign o_pipe_flush  = flush_q;
   assign o_dbg_sel     = in_dump;
   assign o_dump_valid  = in_dump;
   assign o_dbg_addr    = dbg_addr_q;
   assign o_state       = state_q;

endmodule

`default_nettype wire

// File: tb/tb_pipeline_run_controller.sv
// ============================================================================
// Module   : tb_pipeline_run_controller
// Brief    : Directed self-checking bench for pipeline_run_controller.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipeline_run_controller;

   localparam int STEP_N = 3;
`ifdef PIPELINE_CYCLE_COUNTER_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        i_rst_n = 1'b0;
   logic        i_cmd_valid = 1'b0;
   logic [1:0]  i_cmd = 2'b00;
   logic        o_cmd_ready;
   logic        i_halt = 1'b0;
   logic        o_pipe_enable;
   logic        o_pipe_flush;
   logic        o_dbg_sel;
   logic [4:0]  o_dbg_addr;
   logic        o_dump_valid;
   logic        i_dump_ready = 1'b0;
   logic [2:0]  o_state;
   logic [31:0] o_cycle_count;

   int n_checks = 0;
   int n_errors = 0;

   pipeline_run_controller #(.STEP_CYCLES(STEP_N)) dut (
      .clk           (clk),
      .i_rst_n       (i_rst_n),
      .i_cmd_valid   (i_cmd_valid),
      .i_cmd         (i_cmd),
      .o_cmd_ready   (o_cmd_ready),
      .i_halt        (i_halt),
      .o_pipe_enable (o_pipe_enable),
      .o_pipe_flush  (o_pipe_flush),
      .o_dbg_sel     (o_dbg_sel),
      .o_dbg_addr    (o_dbg_addr),
      .o_dump_valid  (o_dump_valid),
      .i_dump_ready  (i_dump_ready),
      .o_state       (o_state),
      .o_cycle_count (o_cycle_count)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_cmd(input logic [1:0] c);
      i_cmd_valid = 1'b1;
      i_cmd       = c;
      tick();
      i_cmd_valid = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check_eq({tag, "_state"}, 32'(o_state), 32'd0);
      check_eq({tag, "_en"},    32'(o_pipe_enable), 32'd0);
      check_eq({tag, "_flush"}, 32'(o_pipe_flush), 32'd0);
      check_eq({tag, "_sel"},   32'(o_dbg_sel), 32'd0);
      check_eq({tag, "_valid"}, 32'(o_dump_valid), 32'd0);
      check_eq({tag, "_addr"},  32'(o_dbg_addr), 32'd0);
      check_eq({tag, "_cnt"},   o_cycle_count, 32'd0);
      check_eq({tag, "_rdy"},   32'(o_cmd_ready), 32'd1);
   endtask

   task automatic do_reset(input string tag);
      @(negedge clk);
      i_rst_n = 1'b0;
      #2;
      check_reset_outputs(tag);
      @(negedge clk);
      i_rst_n = 1'b1;
      tick();
   endtask

   int en_cycles;
   int exp_addr;
   int guard;
   logic [4:0] prev_addr;

   initial begin
      // Reset values
      #3;
      check_reset_outputs("por");
      @(negedge clk);
      i_rst_n = 1'b1;
      tick();

      // STOP in IDLE is ignored
      send_cmd(2'b11);
      check_eq("idle_stop_state", 32'(o_state), 32'd0);

      // STEP runs exactly STEP_N enabled cycles
      send_cmd(2'b01);
      check_eq("step_state", 32'(o_state), 32'd2);
      check_eq("step_rdy", 32'(o_cmd_ready), 32'd0);
      en_cycles = 0;
      for (int i = 0; i < 20; i++) begin
         if (o_state == 3'd0) break;
         if (o_pipe_enable) en_cycles++;
         tick();
      end
      check_eq("step_en_cycles", 32'(en_cycles), 32'(STEP_N));
      check_eq("step_end_state", 32'(o_state), 32'd0);
      check_eq("step_cnt", o_cycle_count, CNT_EN ? 32'd3 : 32'd0);

      // RUN, then halt during the 10th enabled cycle
      do_reset("rst1");
      send_cmd(2'b00);
      check_eq("run_state", 32'(o_state), 32'd1);
      check_eq("run_en", 32'(o_pipe_enable), 32'd1);
      check_eq("run_rdy", 32'(o_cmd_ready), 32'd1);
      send_cmd(2'b01);
      check_eq("run_step_ignored", 32'(o_state), 32'd1);
      for (int i = 0; i < 8; i++) tick();
      i_halt = 1'b1;
      tick();
      i_halt = 1'b0;
      check_eq("halt_state", 32'(o_state), 32'd4);
      check_eq("halt_en", 32'(o_pipe_enable), 32'd0);
      check_eq("halt_cnt", o_cycle_count, CNT_EN ? 32'd10 : 32'd0);
      check_eq("halt_rdy", 32'(o_cmd_ready), 32'd1);

      // DUMP from DONE with ready low every other cycle
      send_cmd(2'b10);
      check_eq("dump_state", 32'(o_state), 32'd3);
      check_eq("dump_sel", 32'(o_dbg_sel), 32'd1);
      check_eq("dump_valid", 32'(o_dump_valid), 32'd1);
      check_eq("dump_rdy", 32'(o_cmd_ready), 32'd0);
      exp_addr = 0;
      guard = 0;
      while (exp_addr < 32 && guard < 200) begin
         i_dump_ready = guard[0];
         prev_addr = o_dbg_addr;
         if (i_dump_ready) begin
            check_eq("dump_addr", 32'(o_dbg_addr), 32'(exp_addr));
            exp_addr++;
         end
         tick();
         if (!i_dump_ready && o_state == 3'd3)
            check_eq("dump_hold", 32'(o_dbg_addr), 32'(prev_addr));
         guard++;
      end
      i_dump_ready = 1'b0;
      check_eq("dump_timeout", 32'(exp_addr), 32'd32);
      check_eq("dump_ret_done", 32'(o_state), 32'd4);
      check_eq("dump_addr_clr", 32'(o_dbg_addr), 32'd0);
      check_eq("dump_sel_off", 32'(o_dbg_sel), 32'd0);

      // STOP from DONE: one flush pulse, counter cleared
      send_cmd(2'b11);
      check_eq("stop_state", 32'(o_state), 32'd0);
      check_eq("stop_flush", 32'(o_pipe_flush), 32'd1);
      tick();
      check_eq("stop_flush_end", 32'(o_pipe_flush), 32'd0);
      check_eq("stop_cnt_clr", o_cycle_count, 32'd0);

      // STOP in RUN without halt returns to IDLE, no flush
      send_cmd(2'b00);
      send_cmd(2'b11);
      check_eq("run_stop_state", 32'(o_state), 32'd0);
      check_eq("run_stop_flush", 32'(o_pipe_flush), 32'd0);

      // halt and STOP in the same cycle: halt wins
      send_cmd(2'b00);
      i_halt = 1'b1;
      send_cmd(2'b11);
      i_halt = 1'b0;
      check_eq("halt_stop_state", 32'(o_state), 32'd4);
      check_eq("halt_stop_flush", 32'(o_pipe_flush), 32'd0);
      tick();
      check_eq("halt_stop_flush2", 32'(o_pipe_flush), 32'd0);

      // Asynchronous reset mid-DUMP at address 17
      do_reset("rst2");
      send_cmd(2'b10);
      i_dump_ready = 1'b1;
      guard = 0;
      while (o_dbg_addr != 5'd17 && guard < 40) begin
         tick();
         guard++;
      end
      i_dump_ready = 1'b0;
      check_eq("dump17_reached", 32'(o_dbg_addr), 32'd17);
      #2;
      i_rst_n = 1'b0;
      #1;
      check_reset_outputs("rst_mid");
      @(negedge clk);
      i_rst_n = 1'b1;
      tick();
      send_cmd(2'b10);
      check_eq("redump_addr", 32'(o_dbg_addr), 32'd0);
      check_eq("redump_state", 32'(o_state), 32'd3);
      i_dump_ready = 1'b1;
      for (int i = 0; i < 32; i++) tick();
      i_dump_ready = 1'b0;
      check_eq("redump_ret_idle", 32'(o_state), 32'd0);

      // RUN for 50 cycles
      do_reset("rst3");
      send_cmd(2'b00);
      for (int i = 0; i < 50; i++) tick();
      check_eq("run50_cnt", o_cycle_count, CNT_EN ? 32'd50 : 32'd0);
      send_cmd(2'b11);
      check_eq("run50_stop", 32'(o_state), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule

`default_nettype wire
